// File: rtl/c1355_sec_encoder_if.sv
// Stream bundle for the c1355 SEC encoder: word input with fault-injection
// controls, and the buffered codeword output feeding the corrector G inputs.
interface c1355_sec_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_chk_en;
    logic        inj_arm;
    logic [5:0]  inj_pos;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [7:0]  out_check;
    logic        out_chk_en;
    logic        out_injected;

    modport master (
        output in_valid, in_data, in_chk_en, inj_arm, inj_pos, out_ready,
        input  in_ready, out_valid, out_data, out_check, out_chk_en, out_injected
    );

    modport slave (
        input  in_valid, in_data, in_chk_en, inj_arm, inj_pos, out_ready,
        output in_ready, out_valid, out_data, out_check, out_chk_en, out_injected
    );
endinterface

// File: rtl/c1355_sec_encoder.sv
// Check-bit generator for the 32-bit c1355 single-error corrector.
// Encodes accepted words combinationally, optionally flips one codeword bit
// (one-shot, armed ahead of time), and presents the result through a
// 2-entry in-order buffer.
module c1355_sec_encoder #(
    parameter int WCNT_W     = 16,
    parameter int ICNT_W     = 8,
    parameter int INJ_ENABLE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    c1355_sec_encoder_if.slave    bus,
    output logic [WCNT_W-1:0]     word_cnt,
    output logic [ICNT_W-1:0]     inj_cnt
);

    // Data-bit membership of each check bit; index k selects check[k].
    localparam logic [7:0][31:0] CHK_MASK = {
        32'h8888_F0F0,  // c7
        32'h4444_0F0F,  // c6
        32'h2222_FF00,  // c5
        32'h1111_00FF,  // c4
        32'hF0F0_8888,  // c3
        32'h0F0F_4444,  // c2
        32'hFF00_2222,  // c1
        32'h00FF_1111   // c0
    };

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  check;
        logic        chk_en;
        logic        injected;
    } entry_t;

    entry_t      mem [2];
    logic        rd_ptr;
    logic        wr_ptr;
    logic [1:0]  count;

    logic        armed;
    logic [5:0]  arm_pos;

    logic [7:0]  enc_check;
    logic        accept;
    logic        pop;
    logic        flip_hit;
    logic [39:0] flip_vec;
    logic [39:0] codeword;
    entry_t      new_entry;

    // Even parity per check bit over its data subset
    for (genvar k = 0; k < 8; k++) begin : g_chk
        assign enc_check[k] = ^(bus.in_data & CHK_MASK[k]);
    end

    assign bus.in_ready  = (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign accept        = bus.in_valid & bus.in_ready;
    assign pop           = bus.out_valid & bus.out_ready;

    // An armed position beyond the codeword still consumes the arm, but flips nothing
    assign flip_hit  = armed && (arm_pos < 6'd40);
    assign flip_vec  = flip_hit ? (40'd1 << arm_pos) : 40'd0;
    assign codeword  = {enc_check, bus.in_data} ^ flip_vec;
    assign new_entry = '{data:     codeword[31:0],
                         check:    codeword[39:32],
                         chk_en:   bus.in_chk_en,
                         injected: flip_hit};

    assign bus.out_data     = mem[rd_ptr].data;
    assign bus.out_check    = mem[rd_ptr].check;
    assign bus.out_chk_en   = mem[rd_ptr].chk_en;
    assign bus.out_injected = mem[rd_ptr].injected;

    // Output buffer: storage cleared on reset so out_* read zero when empty
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(accept) - 2'(pop);
        end
    end

    // Injection arm: consumed by the next accept, new arm wins over consumption
    always_ff @(posedge clk) begin
        if (rst) begin
            armed   <= 1'b0;
            arm_pos <= 6'd0;
        end else begin
            if (accept && armed)
                armed <= 1'b0;
            if ((INJ_ENABLE != 0) && bus.inj_arm) begin
                armed   <= 1'b1;
                arm_pos <= bus.inj_pos;
            end
        end
    end

    // Accepted-word counter wraps; injected-word counter saturates
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt <= '0;
            inj_cnt  <= '0;
        end else begin
            if (accept)
                word_cnt <= word_cnt + 1'b1;
            if (accept && flip_hit && (inj_cnt != '1))
                inj_cnt <= inj_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_c1355_sec_encoder.sv
// Bench for c1355_sec_encoder: directed golden/backpressure/injection/reset
// cases plus a randomized closed loop through a behavioural SEC decoder.
module tb_c1355_sec_encoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] word_cnt;
    logic [7:0]  inj_cnt;

    c1355_sec_encoder_if bus();

    c1355_sec_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .word_cnt (word_cnt),
        .inj_cnt  (inj_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  check;
        logic        chk_en;
        logic        injected;
        logic [31:0] orig;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    logic        m_armed = 1'b0;
    int          m_pos = 0;
    logic [15:0] m_wcnt = '0;
    logic [7:0]  m_icnt = '0;
    logic        rnd_on = 1'b0;

    // Check-bit subsets described as ranges/strides over the data index
    function automatic bit in_set(int k, int i);
        case (k)
            0: return (i < 16 && i % 4 == 0) || (i >= 16 && i < 24);
            1: return (i < 16 && i % 4 == 1) || (i >= 24);
            2: return (i < 16 && i % 4 == 2) || (i >= 16 && i < 20) || (i >= 24 && i < 28);
            3: return (i < 16 && i % 4 == 3) || (i >= 20 && i < 24) || (i >= 28);
            4: return (i < 8) || (i >= 16 && i % 4 == 0);
            5: return (i >= 8 && i < 16) || (i >= 16 && i % 4 == 1);
            6: return (i < 4) || (i >= 8 && i < 12) || (i >= 16 && i % 4 == 2);
            default: return (i >= 4 && i < 8) || (i >= 12 && i < 16) || (i >= 16 && i % 4 == 3);
        endcase
    endfunction

    function automatic logic [7:0] enc(logic [31:0] d);
        logic [7:0] c = '0;
        for (int k = 0; k < 8; k++)
            for (int i = 0; i < 32; i++)
                if (in_set(k, i)) c[k] = c[k] ^ d[i];
        return c;
    endfunction

    // Single-error corrector: syndrome matching a data column flips that bit
    function automatic logic [31:0] dec(logic [31:0] d, logic [7:0] c, logic en);
        logic [7:0]  syn = enc(d) ^ c;
        logic [7:0]  col;
        logic [31:0] r = d;
        if (en && syn != 8'h00)
            for (int i = 0; i < 32; i++) begin
                for (int k = 0; k < 8; k++) col[k] = in_set(k, i);
                if (col == syn) r[i] = ~r[i];
            end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks arm state, counters and expected outputs
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst) begin
            q.delete();
            m_armed = 1'b0;
            m_wcnt  = '0;
            m_icnt  = '0;
        end else begin
            chk("word_cnt", word_cnt, m_wcnt);
            chk("inj_cnt", inj_cnt, m_icnt);
            if (bus.in_valid && bus.in_ready) begin
                e.orig     = bus.in_data;
                e.data     = bus.in_data;
                e.check    = enc(bus.in_data);
                e.chk_en   = bus.in_chk_en;
                e.injected = 1'b0;
                if (m_armed) begin
                    m_armed = 1'b0;
                    if (m_pos < 40) begin
                        if (m_pos < 32) e.data[m_pos] = ~e.data[m_pos];
                        else            e.check[m_pos-32] = ~e.check[m_pos-32];
                        e.injected = 1'b1;
                        if (m_icnt != 8'hFF) m_icnt = m_icnt + 8'd1;
                    end
                end
                q.push_back(e);
                m_wcnt = m_wcnt + 16'd1;
            end
            if (bus.inj_arm) begin
                m_armed = 1'b1;
                m_pos   = int'(bus.inj_pos);
            end
        end
    end

    // Output monitor: compares every popped word against the scoreboard head
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && bus.out_valid && bus.out_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got data %0h with no word pending", bus.out_data);
            end else begin
                e = q.pop_front();
                chk("out_word", {bus.out_data, bus.out_check, bus.out_chk_en, bus.out_injected},
                    {e.data, e.check, e.chk_en, e.injected});
                chk("corrected", dec(bus.out_data, bus.out_check, bus.out_chk_en),
                    e.chk_en ? e.orig : e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word until accepted; optional arm pulse in the first cycle
    task automatic send(input logic [31:0] d, input logic en, input logic do_arm, input logic [5:0] pos);
        logic acc = 1'b0;
        int   n = 0;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_chk_en = en;
        bus.inj_arm   = do_arm;
        bus.inj_pos   = pos;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.in_ready;
            step();
            bus.inj_arm = 1'b0;
            n++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %0h not accepted in 200 cycles", d);
        end
    endtask

    task automatic arm(input logic [5:0] pos);
        bus.inj_arm = 1'b1;
        bus.inj_pos = pos;
        step();
        bus.inj_arm = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic golden(input logic [31:0] d, input logic [7:0] c, input string name);
        send(d, 1'b1, 1'b0, 6'd0);
        @(negedge clk);
        chk({name, "_valid"}, bus.out_valid, 1'b1);
        chk({name, "_check"}, bus.out_check, c);
        step();
    endtask

    initial begin
        logic [31:0] wa, wb, wc;
        logic        acc;
        int          n;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_chk_en = 1'b0;
        bus.inj_arm   = 1'b0;
        bus.inj_pos   = '0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_outs", {bus.out_valid, bus.out_data, bus.out_check, bus.out_chk_en, bus.out_injected},
            '0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_counters", {word_cnt, inj_cnt}, '0);
        step();

        golden(32'h0000_0000, 8'h00, "g_zero");
        golden(32'h0000_0001, 8'h51, "g_bit0");
        golden(32'h8000_0000, 8'h8A, "g_bit31");
        golden(32'hFFFF_FFFF, 8'h00, "g_ones");

        // Check-bit injection, then a clean follow-up
        arm(6'd35);
        send(32'h0, 1'b1, 1'b0, 6'd0);
        @(negedge clk);
        chk("inj35_check", bus.out_check, 8'h08);
        chk("inj35_flag", bus.out_injected, 1'b1);
        chk("inj35_cnt", inj_cnt, 8'd1);
        step();
        send(32'h0, 1'b1, 1'b0, 6'd0);
        @(negedge clk);
        chk("after_inj_clean", {bus.out_injected, bus.out_check}, 9'h000);
        step();

        // Arm in the accept cycle: that word clean, the next one flipped
        send(32'h1234_5678, 1'b1, 1'b1, 6'd0);
        @(negedge clk);
        chk("same_cycle_clean", {bus.out_injected, bus.out_data}, {1'b0, 32'h1234_5678});
        step();
        send(32'h0, 1'b1, 1'b0, 6'd0);
        @(negedge clk);
        chk("pos0_data", bus.out_data, 32'h0000_0001);
        chk("pos0_flag", bus.out_injected, 1'b1);
        step();

        // Out-of-range position: consumed without effect
        arm(6'd45);
        send(32'h0, 1'b1, 1'b0, 6'd0);
        @(negedge clk);
        chk("pos45_clean", {bus.out_injected, bus.out_data, bus.out_check}, '0);
        chk("pos45_cnt", inj_cnt, 8'd2);
        step();
        send(32'h0, 1'b1, 1'b0, 6'd0);
        @(negedge clk);
        chk("pos45_disarmed", bus.out_injected, 1'b0);
        step();

        // Backpressure: two words fill the buffer, the third waits
        do_reset();
        bus.out_ready = 1'b0;
        wa = $urandom; wb = $urandom; wc = $urandom;
        send(wa, 1'b1, 1'b0, 6'd0);
        send(wb, 1'b0, 1'b0, 6'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = wc;
        repeat (3) begin
            @(negedge clk);
            chk("bp_in_ready", bus.in_ready, 1'b0);
            chk("bp_hold", bus.out_data, wa);
        end
        step();
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_in_ready", bus.in_ready, 1'b0);
        acc = 1'b0;
        n = 0;
        step();
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = bus.in_ready;
            step();
            n++;
        end
        bus.in_valid = 1'b0;
        chk("bp_c_accepted", acc, 1'b1);
        repeat (4) step();
        @(negedge clk);
        chk("bp_word_cnt", word_cnt, 16'd3);
        step();

        // Reset with a full buffer and a simultaneous accept attempt
        bus.out_ready = 1'b0;
        send(32'hDEAD_BEEF, 1'b1, 1'b0, 6'd0);
        send(32'hCAFE_F00D, 1'b1, 1'b0, 6'd0);
        @(negedge clk);
        chk("full_before_rst", {bus.out_valid, bus.in_ready}, 2'b10);
        step();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", {bus.out_valid, bus.in_ready}, 2'b01);
        chk("rst_mid_counters", {word_cnt, inj_cnt}, '0);
        step();

        // Random closed loop with periodic injections and random backpressure
        rnd_on = 1'b1;
        fork
            begin
                for (int w = 0; w < 10000; w++) begin
                    if (w % 8 == 3) arm(6'($urandom_range(0, 39)));
                    send($urandom, ($urandom % 8) != 0, 1'b0, 6'd0);
                    if ($urandom % 4 == 0) step();
                end
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    step();
                    bus.out_ready = ($urandom % 5) != 0;
                end
            end
        join
        bus.out_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        chk("drain_pending", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
